// File: rtl/memory_test_hw_ram_pipelined.sv
// memory_test_hw_ram_pipelined: self-initialising single-port RAM slave with pipelined reads.
// Define MEMORY_TEST_HW_RAM_OUTREG_EN to add an output register (read latency 2).
module memory_test_hw_ram_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic {INIT, RUN} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic                  r_vld;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_en, w_acc, w_wr, w_rd;
`ifdef MEMORY_TEST_HW_RAM_OUTREG_EN
  logic                  r_vld2;
  logic [DATA_WIDTH-1:0] r_rdata2;
`endif
  assign w_en        = clken & ~reset_req;
  assign waitrequest = (r_state == INIT) | ~w_en;
  assign w_acc       = chipselect & (read | write) & ~waitrequest;
  assign w_wr        = w_acc & write;
  assign w_rd        = w_acc & ~write;
  assign init_done   = (r_state == RUN);
`ifdef MEMORY_TEST_HW_RAM_OUTREG_EN
  assign readdata      = r_rdata2;
  assign readdatavalid = r_vld2 & w_en;
`else
  assign readdata      = r_rdata;
  assign readdatavalid = r_vld & w_en;
`endif
  // Storage has no reset; only the init sweep clears it.
  always_ff @(posedge clk) begin
    if (reset_n && w_en && r_state == INIT)
      r_mem[r_cnt] <= INIT_VALUE;
    else if (w_wr)
      for (int b = 0; b < BW; b++)
        if (byteenable[b]) r_mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
  end
  // The strobe stays pending across stalls and is shown only on enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_rdata <= '0;
`ifdef MEMORY_TEST_HW_RAM_OUTREG_EN
      r_vld2   <= 1'b0;
      r_rdata2 <= '0;
`endif
    end else if (w_en) begin
      if (r_state == INIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) r_state <= RUN;
      end
      r_vld <= w_rd;
      if (w_rd) r_rdata <= r_mem[address];
`ifdef MEMORY_TEST_HW_RAM_OUTREG_EN
      r_vld2   <= r_vld;
      r_rdata2 <= r_rdata;
`endif
    end
  end
endmodule

// File: doc/memory_test_hw_ram_pipelined.md
MEMORY_TEST_HW_RAM_PIPELINED -- requirements
Module: memory_test_hw_ram_pipelined

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 15: word address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter INIT_VALUE, default 0: word written to every location by the init engine.
REQ-004 clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-005 reset_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-006 chipselect  in  1  slave select.
REQ-007 address  in  ADDR_WIDTH  word address.
REQ-008 byteenable  in  DATA_WIDTH/8  per-byte write enable.
REQ-009 read  in  1  read request.
REQ-010 write  in  1  write request.
REQ-011 writedata  in  DATA_WIDTH  write data.
REQ-012 clken  in  1  global clock enable.
REQ-013 reset_req  in  1  reset-pending freeze request.
REQ-014 readdata  out  DATA_WIDTH  read data.
REQ-015 readdatavalid  out  1  one-cycle strobe qualifying readdata.
REQ-016 waitrequest  out  1  stall; request not accepted while high.
REQ-017 init_done  out  1  high once the init sweep is complete.

Function
REQ-018 FSM states INIT and RUN; INIT SHALL be entered on reset, RUN SHALL be entered after the sweep.
REQ-019 In INIT: one INIT_VALUE write per enabled cycle at counter 0..2**ADDR_WIDTH-1; counter increments by 1; the write at the last address SHALL move the FSM to RUN on the same edge.
REQ-020 waitrequest SHALL be 1 in INIT, and 1 whenever clken=0 or reset_req=1; otherwise 0.
REQ-021 Accept = chipselect & (read | write) & ~waitrequest.
REQ-022 Accepted write: only bytes with byteenable=1 SHALL be updated. byteenable=0 SHALL leave the word unchanged.
REQ-023 Accepted read: readdatavalid SHALL be 1 exactly one cycle later, with the addressed word on readdata.
REQ-024 Back-to-back reads SHALL be accepted every cycle with one readdatavalid per read, in order.
REQ-025 read and write both high: write SHALL be performed; no readdatavalid SHALL be generated.
REQ-026 Read after write to the same address on the next cycle SHALL return the new data.
REQ-027 clken=0 or reset_req=1: memory, counter, FSM and read pipeline SHALL hold.
   - readdatavalid SHALL be 0 while held.
   - A pending read SHALL complete on the first enabled cycle.
REQ-028 readdata SHALL be don't-care when readdatavalid=0.
REQ-029 Requests presented with chipselect=0 SHALL be ignored.

Reset
REQ-030 On reset_n=0, asynchronously:
   - state=INIT, counter=0;
   - readdatavalid=0, init_done=0, waitrequest=1;
   - readdata=0, read pipeline cleared.
REQ-031 A reset during INIT or RUN SHALL restart the sweep at address 0; reads in flight SHALL be discarded.
REQ-032 Memory contents SHALL NOT be reset directly; they are only overwritten by the sweep.

Configuration
REQ-033 Macro MEMORY_TEST_HW_RAM_OUTREG_EN:
   - Defined: an output register SHALL be added, giving read latency 2 cycles. readdatavalid SHALL align with it, and the register SHALL reset to 0.
   - Undefined: read latency SHALL be 1 cycle (REQ-023).
REQ-034 The macro SHALL NOT change throughput, the port list or init timing.

Verification
REQ-035 Release reset with ADDR_WIDTH=4 -> waitrequest=1 for 16 enabled cycles, then init_done=1; reads of all 16 words return INIT_VALUE.
REQ-036 Write 0xDEADBEEF to address 3 with byteenable=0b0101, after init -> read of address 3 returns 0x00AD00EF.
REQ-037 Reads of addresses 0,1,2 on consecutive cycles -> three consecutive readdatavalid pulses, in order; latency 1, or 2 with MEMORY_TEST_HW_RAM_OUTREG_EN.
REQ-038 clken=0 for 5 cycles mid-init -> counter holds and init_done is delayed by exactly 5 cycles; a read accepted just before reset_req is raised completes after reset_req clears.
REQ-039 Assert reset_n=0 while readdatavalid is pending -> no readdatavalid, init_done=0, sweep restarts at 0.
REQ-040 read=1 and write=1 with data 0x12345678 to address 7 -> no readdatavalid; next read of address 7 returns 0x12345678.
